// File: rtl/dma_controller.sv
// Fly-by DMA controller: moves words between a disk and DRAM without touching the
// data bus, arbitrating for the bus with HOLD/HLDA and pacing each word on DREQ.
module dma_controller #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_wdata,
  output logic              HOLD,
  input  logic              HLDA,
  input  logic              DREQ,
  output logic              DACK,
  output logic              IOR,
  output logic              IOW,
  output logic              MEMR,
  output logic              MEMW,
  output logic [ADDR_W-1:0] addressBus_DRAM,
  output logic [ADDR_W-1:0] addressBus_disk,
  output logic              busy,
  output logic              done_irq,
  output logic [CNT_W-1:0]  remaining
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_WAIT_DREQ,
    S_STROBE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_dram_addr;
  logic [ADDR_W-1:0]   r_disk_addr;
  logic [CNT_W-1:0]    r_remaining;
  logic                r_dir;
  logic                r_done_irq;

  logic w_ctrl_wr;
  logic w_start;
  logic w_irq_clr;
  logic w_abort;
  logic w_unused;

  assign w_ctrl_wr = cfg_we && (cfg_sel == 2'd3);
  assign w_start   = w_ctrl_wr && cfg_wdata[0];
  assign w_irq_clr = w_ctrl_wr && cfg_wdata[2];
  assign w_abort   = w_ctrl_wr && cfg_wdata[3];
  // Upper write-data bits are don't-care for every register.
  assign w_unused  = ^cfg_wdata;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_dram_addr <= '0;
      r_disk_addr <= '0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_done_irq  <= 1'b0;
    end else begin
      // A later set in DONE overrides this clear within the same edge.
      if (w_irq_clr) r_done_irq <= 1'b0;

      if (r_state == S_IDLE) begin
        if (cfg_we) begin
          case (cfg_sel)
            2'd0:    r_dram_addr <= cfg_wdata[ADDR_W-1:0];
            2'd1:    r_disk_addr <= cfg_wdata[ADDR_W-1:0];
            2'd2:    r_remaining <= cfg_wdata[CNT_W-1:0];
            default: begin
              if (w_start && !w_abort) begin
                r_dir   <= cfg_wdata[1];
                r_state <= (r_remaining != '0) ? S_ARB : S_DONE;
              end
            end
          endcase
        end
      end else if (w_abort) begin
        // Abort freezes addresses and count where they are.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_ARB: begin
            if (HLDA) r_state <= S_WAIT_DREQ;
          end
          S_WAIT_DREQ: begin
            if (!HLDA)     r_state <= S_ARB;
            else if (DREQ) r_state <= S_STROBE;
          end
          S_STROBE: begin
            r_dram_addr <= r_dram_addr + ADDR_W'(1);
            r_disk_addr <= r_disk_addr + ADDR_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
            r_state     <= (r_remaining == CNT_W'(1)) ? S_DONE : S_WAIT_DREQ;
          end
          S_DONE: begin
            r_done_irq <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Moore decode: every output depends on registered state only.
  assign HOLD            = (r_state == S_ARB) || (r_state == S_WAIT_DREQ) || (r_state == S_STROBE);
  assign DACK            = (r_state == S_WAIT_DREQ) || (r_state == S_STROBE);
  assign IOR             = (r_state == S_STROBE) && !r_dir;
  assign MEMW            = (r_state == S_STROBE) && !r_dir;
  assign MEMR            = (r_state == S_STROBE) &&  r_dir;
  assign IOW             = (r_state == S_STROBE) &&  r_dir;
  assign busy            = (r_state != S_IDLE);
  assign done_irq        = r_done_irq;
  assign remaining       = r_remaining;
  assign addressBus_DRAM = r_dram_addr;
  assign addressBus_disk = r_disk_addr;

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning DRAM and disk word-address width.
REQ-002 SHALL have parameter CNT_W, default 11, meaning transfer-count width (max 1024 words).
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 SHALL have port cfg_we  input  1  CPU register write strobe.
REQ-006 SHALL have port cfg_sel  input  2  register select: 0=DRAM addr, 1=disk addr, 2=count, 3=control.
REQ-007 SHALL have port cfg_wdata  input  32  write data; low bits used per register width.
REQ-008 SHALL have port HOLD  output  1  bus request to CPU.
REQ-009 SHALL have port HLDA  input  1  CPU bus grant.
REQ-010 SHALL have port DREQ  input  1  disk ready-for-word request.
REQ-011 SHALL have port DACK  output  1  disk acknowledge / channel select.
REQ-012 SHALL have ports IOR, IOW, MEMR, MEMW  output  1 each  disk read, disk write, DRAM read, DRAM write strobes.
REQ-013 SHALL have port addressBus_DRAM  output  ADDR_W  current DRAM word address.
REQ-014 SHALL have port addressBus_disk  output  ADDR_W  current disk word address.
REQ-015 SHALL have ports busy, done_irq  output  1 each; remaining  output  CNT_W  words left.

Function
REQ-016 Control word: bit0 start, bit1 dir (0 disk->DRAM, 1 DRAM->disk), bit2 irq clear, bit3 abort.
REQ-017 Writes to sel 0/1/2 SHALL load the register next edge only when state=IDLE; ignored otherwise.
REQ-018 Transfer is fly-by: block never drives the data bus; disk and DRAM exchange data directly.
REQ-019 States: IDLE, ARB, WAIT_DREQ, STROBE, DONE; all outputs decoded from registered state (Moore).
REQ-020 IDLE: start write with count!=0 -> ARB; with count=0 -> DONE directly (no HOLD).
REQ-021 ARB: HOLD=1, busy=1; HLDA=1 sampled -> WAIT_DREQ.
REQ-022 WAIT_DREQ: HOLD=1, DACK=1; DREQ=1 and HLDA=1 -> STROBE; HLDA=0 -> ARB (HOLD kept).
REQ-023 STROBE: exactly one cycle; dir=0 asserts IOR+MEMW, dir=1 asserts MEMR+IOW; DACK=1, HOLD=1.
REQ-024 At end of STROBE both addresses SHALL increment by 1 modulo 2^ADDR_W (1023 wraps to 0) and remaining decrement by 1.
REQ-025 STROBE with remaining=1 -> DONE; else -> WAIT_DREQ. Minimum 2 cycles per word.
REQ-026 DONE: one cycle, HOLD=0, set done_irq (sticky), busy=0 on exit -> IDLE.
REQ-027 done_irq SHALL clear on control write with bit2=1; simultaneous set in DONE wins.
REQ-028 Abort (bit3) in any non-IDLE state -> IDLE next edge, HOLD/strobes drop, done_irq not set, addresses/count keep current values; abort beats start in same write.
REQ-029 Start write while busy SHALL be ignored.
REQ-030 Strobes SHALL never be asserted outside STROBE; IOR/IOW/MEMR/MEMW mutually exclusive per direction.

Reset
REQ-031 RST=1 SHALL force IDLE; HOLD, DACK, IOR, IOW, MEMR, MEMW, busy, done_irq = 0; address registers and remaining = 0; dir=0.
REQ-032 RST mid-transfer SHALL drop all strobes and HOLD on the same edge; no partial strobe afterwards.

Verification
REQ-033 DRAM=0x010, disk=0x020, count=3, dir=0, HLDA after 2 cycles, DREQ held 1 -> 3 IOR+MEMW pulses at DRAM 0x010..0x012, done_irq=1, remaining=0, HOLD low.
REQ-034 DRAM=1022, count=4, dir=1 -> MEMR+IOW at DRAM 1022, 1023, 0, 1; final addressBus_DRAM=2.
REQ-035 count=0, start -> DONE next cycle, done_irq=1, HOLD never asserted.
REQ-036 HLDA dropped after word 2 of 5 -> return to ARB, no strobes until HLDA=1, then words 3..5 complete; exactly 5 strobes total.
REQ-037 Abort after word 1 of 8 -> IDLE, remaining=7, done_irq=0; RST mid-STROBE -> all outputs 0 next edge.
REQ-038 Config write to sel 0 while busy -> register unchanged; irq clear write -> done_irq=0.
